if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the pipelined core. It owns the architectural fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake. It buffers returned instructions and presents them to the decode stage through the IF/ID pipeline register. Sequential fetch uses its own PC+4; redirects take the target from `nextPC`'s `NPC` output.

## Interface
- `RESET_PC`, 32'h1C000000, fetch address after reset.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_o`  out  32  current fetch PC register; drives `nextPC.PC`.
- `npc_i`  in  32  `nextPC.NPC`; used only when `redirect_i`=1.
- `redirect_i`  in  1  taken branch/jump/exception resolved; flush younger fetches, load `npc_i`.
- `stall_i`  in  1  decode cannot accept; IF/ID holds.
- `imem_req_o`  out  1  fetch request valid.
- `imem_addr_o`  out  32  fetch address (= `pc_o`).
- `imem_gnt_i`  in  1  request accepted this cycle.
- `imem_rvalid_i`  in  1  response data valid; responses in request order.
- `imem_rdata_i`  in  32  instruction word.
- `if_valid_o`  out  1  IF/ID register holds a valid instruction.
- `if_pc_o`  out  32  PC of IF/ID instruction.
- `if_inst_o`  out  32  IF/ID instruction word.

## Operation
- Reset: `pc_o`=RESET_PC, FSM=IDLE, queue empty, outstanding=0, drop count=0, `if_valid_o`=0, `if_pc_o`=0, `if_inst_o`=32'h00000013 (NOP), `imem_req_o`=0.
- FSM IDLE -> RUN unconditionally after the first post-reset cycle; RUN is held until `rst`.
- In RUN, `imem_req_o`=1 when outstanding + queue occupancy < DEPTH (DEPTH per Configuration). `imem_addr_o`=`pc_o`.
- Address may change while ungranted; memory samples it only on `imem_gnt_i`.
- Grant (req & gnt, no redirect): `pc_o` <= `pc_o`+4, modulo 2^32 (32'hFFFFFFFC wraps to 0); outstanding+1.
- Response (`imem_rvalid_i`): outstanding-1.
  - If drop count>0: discard it, drop count-1.
  - Otherwise push {PC, inst}; the PC is taken from an in-order tag FIFO written at grant.
- IF/ID load when `!if_valid_o || !stall_i`: pop the queue head; if the queue is empty and a live response arrives, bypass it directly into IF/ID. If nothing is available, `if_valid_o` <= 0.
- Redirect (priority over stall, grant and response):
  - `pc_o` <= `npc_i`; queue cleared; `if_valid_o` <= 0.
  - Drop count <= outstanding after this cycle's grant/response. A grant in the redirect cycle counts as outstanding; a response in the redirect cycle is discarded.
  - `pc_o` is not incremented that cycle.
- Reset mid-operation: all state cleared. Instruction memory shares `rst`, so no stale response arrives after reset.
- `rvalid` with outstanding=0 is a protocol error; it is ignored and the counter does not underflow.

## Timing
- Grant at cycle t, earliest `rvalid` at t+1. With an empty queue and no stall, `if_valid_o`=1 from t+2.
- Back-to-back grants with 1-cycle memory give one instruction per cycle at full throughput.
- Redirect at cycle t: `imem_addr_o`=`npc_i` value at t+1; `if_valid_o`=0 at t+1.
- Stall: `if_pc_o`/`if_inst_o` are bit-stable while `if_valid_o & stall_i`.

## Configuration
- `IF_SKID_BUF_EN` defined: DEPTH=2. A 2-entry instruction queue lets fetch run ahead during a decode stall; up to 2 requests are outstanding.
- Undefined: DEPTH=1. A single holding entry is used, one request at most is outstanding, and fetch issues nothing while the holding entry or an in-flight response would overflow.

## Test plan
- Reset then 1-cycle memory, `gnt`=1 always: `imem_addr_o` = 1C000000, 1C000004, 1C000008; `if_pc_o` follows two cycles later with `if_valid_o`=1 continuously.
- `stall_i`=1 for 4 cycles with the IF/ID holding PC 1C000004: IF/ID is stable; `imem_req_o` drops after 1 (DEPTH=1) or 2 (DEPTH=2) in-flight/queued entries; no instruction is lost or duplicated after release.
- `redirect_i`=1 with `npc_i`=1C090000 while one response is in flight: the in-flight response is discarded; the next `if_pc_o` is 1C090000 and `if_valid_o`=0 for the cycle after redirect.
- Redirect in the same cycle as `rvalid` and `gnt`: the response is dropped, the granted request is dropped later, and the next delivered PC is `npc_i`.
- `gnt` held low for 3 cycles, then a redirect to 1C000100 while ungranted: `imem_addr_o` switches to 1C000100 before grant; no drop is recorded.
- Redirect to FFFFFFFC: the next fetch addresses are FFFFFFFC then 00000000.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives an in-order req/gnt/rvalid memory port, feeds IF/ID.
// Define IF_SKID_BUF_EN for a 2-entry instruction queue (DEPTH=2); otherwise one holding entry (DEPTH=1).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_o,
    input  logic [31:0] npc_i,
    input  logic        redirect_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

`ifdef IF_SKID_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic        w_run;

    logic [31:0] r_pc;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_dropCnt;
    logic [31:0] r_tag [2];

    logic [1:0]  r_qCount;
    logic [31:0] r_qPc [2];
    logic [31:0] r_qInst [2];

    logic        r_ifValid;
    logic [31:0] r_ifPc;
    logic [31:0] r_ifInst;

    logic        w_req;
    logic        w_grant;
    logic        w_rspValid;
    logic        w_rspLive;
    logic        w_load;
    logic        w_pop;
    logic        w_bypass;
    logic        w_push;
    logic        w_qWrIdx;
    logic        w_tagWrIdx;
    logic [1:0]  w_qCountNext;
    logic [1:0]  w_outNext;
    logic [2:0]  w_slots;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    w_stateNext = RUN;
            RUN:     w_stateNext = RUN;
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        w_run = 1'b0;
        if (r_state == RUN) begin
            w_run = 1'b1;
        end
    end

    // Stray rvalid with nothing outstanding is ignored; dropped or flushed responses never reach IF/ID.
    assign w_rspValid   = imem_rvalid_i && (r_outstanding != 2'd0);
    assign w_rspLive    = w_rspValid && (r_dropCnt == 2'd0) && !redirect_i;
    assign w_load       = !r_ifValid || !stall_i;
    assign w_pop        = w_load && (r_qCount != 2'd0);
    assign w_bypass     = w_load && (r_qCount == 2'd0) && w_rspLive;
    assign w_push       = w_rspLive && !w_bypass;
    assign w_qCountNext = r_qCount - 2'(w_pop) + 2'(w_push);
    assign w_qWrIdx     = r_qCount[0] ^ w_pop;
    assign w_tagWrIdx   = r_outstanding[0] ^ w_rspValid;

    // Credit check looks at occupancy after this cycle's response and IF/ID load, so a
    // single-entry build still sustains one fetch per cycle with a 1-cycle memory.
    assign w_slots   = 3'(r_outstanding) - 3'(w_rspValid) + 3'(w_qCountNext);
    assign w_req     = w_run && (w_slots < 3'(DEPTH));
    assign w_grant   = w_req && imem_gnt_i;
    assign w_outNext = r_outstanding + 2'(w_grant) - 2'(w_rspValid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= 2'd0;
            r_dropCnt     <= 2'd0;
        end else begin
            r_outstanding <= w_outNext;
            if (redirect_i) begin
                r_pc      <= npc_i;
                r_dropCnt <= w_outNext;
            end else begin
                if (w_grant) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_rspValid && (r_dropCnt != 2'd0)) begin
                    r_dropCnt <= r_dropCnt - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag[0] <= 32'd0;
            r_tag[1] <= 32'd0;
        end else begin
            if (w_rspValid) begin
                r_tag[0] <= r_tag[1];
            end
            if (w_grant) begin
                r_tag[w_tagWrIdx] <= r_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_qCount   <= 2'd0;
            r_qPc[0]   <= 32'd0;
            r_qPc[1]   <= 32'd0;
            r_qInst[0] <= NOP;
            r_qInst[1] <= NOP;
        end else if (redirect_i) begin
            r_qCount <= 2'd0;
        end else begin
            if (w_pop) begin
                r_qPc[0]   <= r_qPc[1];
                r_qInst[0] <= r_qInst[1];
            end
            if (w_push) begin
                r_qPc[w_qWrIdx]   <= r_tag[0];
                r_qInst[w_qWrIdx] <= imem_rdata_i;
            end
            r_qCount <= w_qCountNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifValid <= 1'b0;
            r_ifPc    <= 32'd0;
            r_ifInst  <= NOP;
        end else if (redirect_i) begin
            r_ifValid <= 1'b0;
        end else if (w_load) begin
            if (w_pop) begin
                r_ifValid <= 1'b1;
                r_ifPc    <= r_qPc[0];
                r_ifInst  <= r_qInst[0];
            end else if (w_bypass) begin
                r_ifValid <= 1'b1;
                r_ifPc    <= r_tag[0];
                r_ifInst  <= imem_rdata_i;
            end else begin
                r_ifValid <= 1'b0;
            end
        end
    end

    assign pc_o        = r_pc;
    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;
    assign if_valid_o  = r_ifValid;
    assign if_pc_o     = r_ifPc;
    assign if_inst_o   = r_ifInst;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a 1-cycle memory responder, directed fetch/stall/redirect
// sequence, and a monitor that checks every instruction decode accepts against the expected PC order.
module tb_if_fetch_stage;

`ifdef IF_SKID_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] RESET_PC = 32'h1C000000;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_o;
    logic [31:0] npc_i;
    logic        redirect_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] expQ[$];
    logic        memPend = 1'b0;
    logic [31:0] memPendData = 32'd0;

    if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_o         (pc_o),
        .npc_i        (npc_i),
        .redirect_i   (redirect_i),
        .stall_i      (stall_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'h00000013;
    endfunction

    // Memory model: a grant seen in one cycle returns its word in the next cycle.
    always @(negedge clk) begin
        memPend     = !rst && imem_req_o && imem_gnt_i;
        memPendData = memData(imem_addr_o);
    end

    always @(posedge clk) begin
        #1;
        imem_rvalid_i = memPend;
        imem_rdata_i  = memPendData;
    end

    // An instruction counts as delivered when decode accepts it: valid, not stalled, not flushed.
    always @(negedge clk) begin
        logic [31:0] expPc;
        if (!rst && if_valid_o && !stall_i && !redirect_i) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboardExtra: delivered pc %h, expected no delivery", if_pc_o);
            end else begin
                expPc = expQ.pop_front();
                if (if_pc_o !== expPc) begin
                    errors++;
                    $display("[TB] FAIL scoreboardPc: got %h, expected %h", if_pc_o, expPc);
                end
                checks++;
                if (if_inst_o !== memData(expPc)) begin
                    errors++;
                    $display("[TB] FAIL scoreboardInst: got %h, expected %h", if_inst_o, memData(expPc));
                end
            end
        end
    end

    task automatic applyStimulus(input logic rstV, input logic stallV, input logic gntV,
                                 input logic redirV, input logic [31:0] npcV);
        @(posedge clk);
        #1;
        rst        = rstV;
        stall_i    = stallV;
        imem_gnt_i = gntV;
        redirect_i = redirV;
        npc_i      = npcV;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Pc"}, pc_o, RESET_PC);
        checkOutput({tag, "Req"}, 32'(imem_req_o), 32'd0);
        checkOutput({tag, "IfValid"}, 32'(if_valid_o), 32'd0);
        checkOutput({tag, "IfPc"}, if_pc_o, 32'd0);
        checkOutput({tag, "IfInst"}, if_inst_o, NOP);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst           = 1'b1;
        stall_i       = 1'b0;
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b0;
        npc_i         = 32'd0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");

        // First post-reset cycle is IDLE: no request yet.
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("idleReq", 32'(imem_req_o), 32'd0);

        // Sequential fetch, then a 4-cycle stall with IF/ID holding 1C000004.
        expQ.push_back(32'h1C000000);
        expQ.push_back(32'h1C000004);
        expQ.push_back(32'h1C000008);
        expQ.push_back(32'h1C00000C);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("seqReq0", 32'(imem_req_o), 32'd1);
        checkOutput("seqAddr0", imem_addr_o, 32'h1C000000);
        checkOutput("seqValid0", 32'(if_valid_o), 32'd0);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("seqAddr1", imem_addr_o, 32'h1C000004);
        checkOutput("seqValid1", 32'(if_valid_o), 32'd0);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("seqAddr2", imem_addr_o, 32'h1C000008);
        checkOutput("seqValid2", 32'(if_valid_o), 32'd1);
        checkOutput("seqIfPc2", if_pc_o, 32'h1C000000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 0, 32'd0);
            checkOutput("stallValid", 32'(if_valid_o), 32'd1);
            checkOutput("stallIfPc", if_pc_o, 32'h1C000004);
            checkOutput("stallIfInst", if_inst_o, memData(32'h1C000004));
            checkOutput("stallReq", 32'(imem_req_o), (i == 0 && DEPTH == 2) ? 32'd1 : 32'd0);
        end
        repeat (3) applyStimulus(0, 0, 1, 0, 32'd0);

        // Redirect with one response in flight and no grant in the same cycle.
        applyStimulus(0, 0, 0, 1, 32'h1C090000);
        expQ.push_back(32'h1C090000);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("redirValid", 32'(if_valid_o), 32'd0);
        checkOutput("redirAddr", imem_addr_o, 32'h1C090000);
        checkOutput("redirReq", 32'(imem_req_o), 32'd1);
        applyStimulus(0, 0, 1, 0, 32'd0);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("redirFirstValid", 32'(if_valid_o), 32'd1);
        checkOutput("redirFirstPc", if_pc_o, 32'h1C090000);

        // Redirect coinciding with both rvalid and gnt: both responses are discarded.
        applyStimulus(0, 0, 1, 1, 32'h1C0A0000);
        expQ.push_back(32'h1C0A0000);
        expQ.push_back(32'h1C0A0004);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("dropValid0", 32'(if_valid_o), 32'd0);
        checkOutput("dropAddr", imem_addr_o, 32'h1C0A0000);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("dropValid1", 32'(if_valid_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 32'd0);
        checkOutput("dropFirstPc", if_pc_o, 32'h1C0A0000);

        // Grant withheld for 3 cycles, then redirect while the request is still ungranted.
        repeat (2) applyStimulus(0, 0, 0, 0, 32'd0);
        checkOutput("ungrantedAddr", imem_addr_o, 32'h1C0A0008);
        applyStimulus(0, 0, 0, 1, 32'h1C000100);
        expQ.push_back(32'h1C000100);
        applyStimulus(0, 0, 0, 0, 32'd0);
        checkOutput("ungrantedRedirAddr", imem_addr_o, 32'h1C000100);
        checkOutput("ungrantedRedirReq", 32'(imem_req_o), 32'd1);
        repeat (3) applyStimulus(0, 0, 1, 0, 32'd0);

        // Redirect to the top of the address space: fetch wraps to zero.
        applyStimulus(0, 0, 1, 1, 32'hFFFFFFFC);
        expQ.push_back(32'hFFFFFFFC);
        expQ.push_back(32'h00000000);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("wrapAddr0", imem_addr_o, 32'hFFFFFFFC);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("wrapAddr1", imem_addr_o, 32'h00000000);
        applyStimulus(0, 0, 0, 0, 32'd0);

        for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
            applyStimulus(0, 0, 0, 0, 32'd0);
        end
        repeat (3) applyStimulus(0, 0, 0, 0, 32'd0);
        checkOutput("scoreboardDrain", 32'(expQ.size()), 32'd0);

        // Reset mid-operation returns everything to the reset state.
        applyStimulus(1, 0, 0, 0, 32'd0);
        applyStimulus(1, 0, 0, 0, 32'd0);
        checkResetState("midReset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
